// File: rtl/led_pattern_pkg.sv
// Mode encoding shared by the LED pattern generator and anything that programs it.
// Pure definitions: no latency, no flow control.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY    = 2'd0,
        MODE_BIN     = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one step every 2^LOG2DELAY unpaused clocks; step is registered (1 clock after tick).
// No backpressure: pause freezes the count, clr restarts it and suppresses a coincident tick.
module tick_prescaler #(
    parameter int LOG2DELAY = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic pause,
    output logic tick,
    output logic step
);

    logic [LOG2DELAY-1:0] cnt;

    // tick marks the edge on which the pattern state advances; step is its registered copy
    assign tick = (&cnt) & ~pause & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            step <= tick;
            if (clr) begin
                cnt <= '0;
            end else if (!pause) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator (gray, binary, scanner, PWM breathe) advancing on prescaler steps.
// led lags the state update by one clock; no backpressure, pause freezes pattern state only.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_COUNT = 5,
    parameter int LOG2DELAY = 21,
    parameter int PWM_BITS  = 8
) (
    input  logic                 clki,
    input  logic                 resetn,
    input  logic [1:0]           mode_i,
    input  logic                 mode_load_i,
    input  logic                 pause_i,
    output logic [LED_COUNT-1:0] led,
    output logic                 step_o,
    output logic [1:0]           mode_o
);

    localparam int                  POS_W    = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(LED_COUNT - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    mode_t                mode;
    logic [LED_COUNT-1:0] count;
    logic [POS_W-1:0]     pos;
    logic                 dir;
    logic [PWM_BITS-1:0]  duty;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 tick;

    tick_prescaler #(
        .LOG2DELAY(LOG2DELAY)
    ) u_prescaler (
        .clk  (clki),
        .rst_n(resetn),
        .clr  (mode_load_i),
        .pause(pause_i),
        .tick (tick),
        .step (step_o)
    );

    assign mode_o = mode;

    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            mode    <= MODE_GRAY;
            count   <= '0;
            pos     <= '0;
            dir     <= 1'b1;
            duty    <= '0;
            pwm_cnt <= '0;
            led     <= '0;
        end else if (mode_load_i) begin
            // a load restarts the new pattern from scratch and blanks the LEDs for one clock
            mode    <= mode_t'(mode_i);
            count   <= '0;
            pos     <= '0;
            dir     <= 1'b1;
            duty    <= '0;
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                case (mode)
                    MODE_GRAY, MODE_BIN: count <= count + 1'b1;
                    MODE_SCAN: begin
                        if (LED_COUNT == 1) begin
                            pos <= '0;
                        end else if (dir) begin
                            if (pos == POS_MAX) begin
                                dir <= 1'b0;
                                pos <= POS_MAX - 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else if (pos == '0) begin
                            dir <= 1'b1;
                            pos <= POS_W'(1);
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                    default: begin
                        // endpoints are reflected so each extreme duty lasts exactly one step
                        if (dir) begin
                            if (duty == DUTY_MAX) begin
                                dir  <= 1'b0;
                                duty <= DUTY_MAX - 1'b1;
                            end else begin
                                duty <= duty + 1'b1;
                            end
                        end else if (duty == '0) begin
                            dir  <= 1'b1;
                            duty <= PWM_BITS'(1);
                        end else begin
                            duty <= duty - 1'b1;
                        end
                    end
                endcase
            end
            case (mode)
                MODE_GRAY:    led <= count ^ (count >> 1);
                MODE_BIN:     led <= count;
                MODE_SCAN:    led <= LED_COUNT'(1) << pos;
                MODE_BREATHE: led <= {LED_COUNT{pwm_cnt < duty}};
            endcase
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator, successor to the single-mode Gray-code blinker.
- A free-running prescaler produces a step tick every 2^LOG2DELAY clocks.
- The selected pattern engine (Gray count, binary count, bouncing scanner or PWM "breathe") advances on each tick and drives LED_COUNT registered outputs.
- Sits directly between the board clock and the LED pins; mode is loaded from board switches or a host register.

Parameters:
- LED_COUNT, 5, number of LED outputs (>=1).
- LOG2DELAY, 21, log2 of clocks per pattern step (>=1).
- PWM_BITS, 8, resolution of breathe-mode PWM (>=2).

Ports:
- clki  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- mode_i  in  2  requested mode: 0 gray, 1 binary, 2 scanner, 3 breathe.
- mode_load_i  in  1  single-cycle strobe; latch mode_i.
- pause_i  in  1  level; freezes prescaler and pattern state.
- led  out  LED_COUNT  registered LED drive, active-high.
- step_o  out  1  one-cycle pulse, asserted on the cycle the pattern state advances.
- mode_o  out  2  currently active mode.

Behaviour:
Reset (resetn low, asynchronous):
- led=0, step_o=0, mode_o=0 (gray).
- Prescaler=0, count=0, pos=0, dir=up, duty=0, pwm_cnt=0.

Prescaler:
- LOG2DELAY-bit up-counter; increments every clock unless pause_i=1.
- step_o=1 combinationally-registered when the prescaler holds all-ones and pause_i=0. It is registered as a pulse aligned with the state update edge.
- Prescaler wraps to 0 on that same edge.
- Exactly one step per 2^LOG2DELAY unpaused clocks.

Pattern state (updates only on edges where step condition is true):
- Gray (0): count (LED_COUNT bits) += 1, wrapping modulo 2^LED_COUNT; led <= count ^ (count>>1).
- Binary (1): same count; led <= count.
- Scanner (2): one-hot led[pos].
  - pos moves by 1 in dir. At pos=LED_COUNT-1 with dir=up: dir<=down, pos<=LED_COUNT-2. Symmetric at pos=0 with dir=down.
  - End LEDs are lit for one step per pass.
  - LED_COUNT=1: pos stays 0, led=1 constantly.
- Breathe (3): duty (PWM_BITS) triangle-ramps by 1 per step, 0 -> 2^PWM_BITS-1 -> 0.
  - Reverses at each endpoint; each endpoint value is held for exactly one step.
  - pwm_cnt (PWM_BITS) increments every clock, including during pause.
  - All led bits <= (pwm_cnt < duty). duty=0 gives fully off; duty=max gives off for 1 clock per PWM period.

Output timing:
- led is registered from post-update state. led reflects a step one clock after step_o is high; the breathe compare is also one clock behind.

Mode load:
- mode_load_i=1 at an edge: mode_o<=mode_i.
- Same edge clears the prescaler, count, pos, dir=up, duty and pwm_cnt.
- Any step coincident with the load is discarded.
- led is 0 on the following clock, then the new pattern starts from its initial state.
- Loading the same mode also restarts it.
- mode_load_i has priority over pause_i. The pause state persists after the load.

Pause:
- While pause_i=1: prescaler and pattern state hold, step_o=0, led holds its last value.
- Exception: in breathe mode PWM output continues at the frozen duty.
- Deasserting pause resumes from the held prescaler count; no step is lost or duplicated.

Reset mid-operation:
- Immediate return to reset values regardless of mode or pause.

Widths:
- All counters are unsigned and wrap naturally.
- No arithmetic wider than max(LED_COUNT, LOG2DELAY, PWM_BITS)+1.

Decomposition:
- Package led_pattern_pkg: 2-bit mode encoding constants MODE_GRAY=0, MODE_BIN=1, MODE_SCAN=2, MODE_BREATHE=3, and the mode typedef.
- Sub-module tick_prescaler(LOG2DELAY): counter, pause, synchronous clear, step pulse.
- Pattern engines stay inline in led_pattern_gen.

Test Plan (LED_COUNT=5, LOG2DELAY=3, PWM_BITS=3 unless noted):
1. Reset, then run 8*32 clocks in gray mode -> step_o every 8 clocks; led sequence 00000,00001,00011,00010,00110,... Wraps to 00000 after 32 steps.
2. Load mode 2 -> led one-hot 00001,00010,00100,01000,10000,01000,...,00001; endpoints each lit one step; repeat with LED_COUNT=1 -> led=1 always.
3. Load mode 3 -> duty 0..7..0 per step. At duty=3, led high 3 of every 8 clocks. At duty=0 led is never high; at duty=7 led is low exactly 1 clock per 8.
4. Gray mode, assert pause_i for 20 clocks mid-interval -> step_o stays 0 and led is frozen; after release the next step arrives after exactly the remaining prescaler clocks.
5. Assert mode_load_i (mode 1) on the same cycle step would fire -> no step_o pulse; led=0 next clock; binary count restarts at 00001 after 8 clocks.
6. Drop resetn asynchronously mid-scanner sweep -> led=0, mode_o=0 immediately; after release, gray sequence restarts from 00000.
